// File: rtl/laner_pkg.sv
// Shared screen geometry, pixel record and arbiter state encodings for the
// VGA write path (screen_eraser, sprite drawers, vga_write_arbiter).
package laner_pkg;

  localparam int XSCREEN = 640;
  localparam int YSCREEN = 480;
  localparam int COLOR_W = 9;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  localparam logic [COLOR_W-1:0] BLACK = 9'b000_000_000;

  typedef enum logic [1:0] {
    DRAW    = 2'd0,
    ERASE   = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // True when the pixel lands on the visible screen.
  function automatic logic in_screen(input pixel_t p);
    return (int'(p.x) < XSCREEN) && (int'(p.y) < YSCREEN);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on
// contention the pointer picks the winner. The pointer moves to the
// requester that was not served, and only on cycles that issue a grant.
module rr_arb2 (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr=0: requester 0 has priority on contention, ptr=1: requester 1
  logic ptr;

  // One-hot grant, forced idle when arbitration is disabled
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Hand priority to the other requester after every grant
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Merges the screen eraser stream and two sprite drawers into one registered
// VGA write stream. The eraser cannot be stalled and always wins; drawers are
// round-robin arbitrated and locked out for the whole erase pass plus a short
// holdoff so fresh sprites are not overwritten by trailing erase writes.
// Optional macro VGA_CLIP_EN: off-screen pixels are accepted but not plotted,
// and counted on the clip_count port.
module vga_write_arbiter
  import laner_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 2  // must be >= 1
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               erase_active,
  input  logic               erase_write,
  input  logic [X_W-1:0]     erase_x,
  input  logic [Y_W-1:0]     erase_y,
  input  logic [COLOR_W-1:0] erase_color,
  input  logic               d0_valid,
  output logic               d0_ready,
  input  logic [X_W-1:0]     d0_x,
  input  logic [Y_W-1:0]     d0_y,
  input  logic [COLOR_W-1:0] d0_color,
  input  logic               d1_valid,
  output logic               d1_ready,
  input  logic [X_W-1:0]     d1_x,
  input  logic [Y_W-1:0]     d1_y,
  input  logic [COLOR_W-1:0] d1_color,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               busy
`ifdef VGA_CLIP_EN
  ,
  output logic [15:0]        clip_count
`endif
);

  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  arb_state_e      state;
  logic [HO_W-1:0] ho_cnt;

  pixel_t     erase_px, d0_px, d1_px, sel_px;
  logic       draw_en;
  logic [1:0] gnt;
  logic       sel_vld;
  logic       px_plot;

  assign erase_px = {erase_x, erase_y, erase_color};
  assign d0_px    = {d0_x, d0_y, d0_color};
  assign d1_px    = {d1_x, d1_y, d1_color};

  // Drawers only compete in DRAW with the eraser fully quiet. Resetn is
  // folded in so ready drops the moment reset asserts, not at the next edge.
  assign draw_en = Resetn && (state == DRAW) && !erase_write && !erase_active;

  rr_arb2 u_rr (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en     (draw_en),
    .req    ({d1_valid, d0_valid}),
    .gnt    (gnt)
  );

  assign d0_ready = gnt[0];
  assign d1_ready = gnt[1];
  assign sel_vld  = erase_write | (|gnt);

  // Source select: eraser first, otherwise whichever drawer holds the grant
  always_comb begin
    sel_px = d0_px;
    if (erase_write)
      sel_px = erase_px;
    else if (gnt[1])
      sel_px = d1_px;
  end

`ifdef VGA_CLIP_EN
  logic sel_in, px_clip;
  assign sel_in  = in_screen(sel_px);
  assign px_plot = sel_vld & sel_in;
  assign px_clip = sel_vld & ~sel_in;

  // Saturating count of accepted-but-dropped off-screen pixels
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      clip_count <= '0;
    else if (px_clip && (clip_count != 16'hFFFF))
      clip_count <= clip_count + 16'd1;
  end
`else
  assign px_plot = sel_vld;
`endif

  // Output register: strobe every cycle, coordinates only move on a plot
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= BLACK;
      vga_plot  <= 1'b0;
    end else begin
      vga_plot <= px_plot;
      if (px_plot) begin
        vga_x     <= sel_px.x;
        vga_y     <= sel_px.y;
        vga_color <= sel_px.color;
      end
    end
  end

  // Erase-pass lockout FSM; busy is registered with the state
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= DRAW;
      ho_cnt <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        DRAW: begin
          if (erase_active || erase_write) begin
            state <= ERASE;
            busy  <= 1'b1;
          end
        end
        ERASE: begin
          if (!erase_active && !erase_write) begin
            state  <= HOLDOFF;
            ho_cnt <= '0;
          end
        end
        HOLDOFF: begin
          if (erase_active) begin
            state  <= ERASE;
            ho_cnt <= '0;
          end else if (ho_cnt == HO_LAST) begin
            state  <= DRAW;
            ho_cnt <= '0;
            busy   <= 1'b0;
          end else begin
            ho_cnt <= ho_cnt + 1'b1;
          end
        end
        default: begin
          state  <= DRAW;
          ho_cnt <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: reset, drawer arbitration, eraser
// priority, holdoff lockout, async reset mid-pass and screen clipping.
module tb_vga_write_arbiter;
  import laner_pkg::*;

  logic               Clock, Resetn;
  logic               erase_active, erase_write;
  logic [X_W-1:0]     erase_x;
  logic [Y_W-1:0]     erase_y;
  logic [COLOR_W-1:0] erase_color;
  logic               d0_valid, d0_ready;
  logic [X_W-1:0]     d0_x;
  logic [Y_W-1:0]     d0_y;
  logic [COLOR_W-1:0] d0_color;
  logic               d1_valid, d1_ready;
  logic [X_W-1:0]     d1_x;
  logic [Y_W-1:0]     d1_y;
  logic [COLOR_W-1:0] d1_color;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COLOR_W-1:0] vga_color;
  logic               vga_plot, busy;
`ifdef VGA_CLIP_EN
  logic [15:0]        clip_count;
`endif

  int passed = 0;
  int total  = 0;

  vga_write_arbiter #(.HOLDOFF_CYCLES(2)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .erase_active (erase_active),
    .erase_write  (erase_write),
    .erase_x      (erase_x),
    .erase_y      (erase_y),
    .erase_color  (erase_color),
    .d0_valid     (d0_valid),
    .d0_ready     (d0_ready),
    .d0_x         (d0_x),
    .d0_y         (d0_y),
    .d0_color     (d0_color),
    .d1_valid     (d1_valid),
    .d1_ready     (d1_ready),
    .d1_x         (d1_x),
    .d1_y         (d1_y),
    .d1_color     (d1_color),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_color    (vga_color),
    .vga_plot     (vga_plot),
    .busy         (busy)
`ifdef VGA_CLIP_EN
    ,
    .clip_count   (clip_count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance to 1 time unit after the next rising edge
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Resetn = 0; erase_active = 0; erase_write = 0;
    erase_x = '0; erase_y = '0; erase_color = '0;
    d0_valid = 0; d0_x = '0; d0_y = '0; d0_color = '0;
    d1_valid = 0; d1_x = '0; d1_y = '0; d1_color = '0;
    #3;
    total++; if (vga_plot !== 1'b0) $display("FAIL reset_plot got %0b exp 0", vga_plot); else passed++;
    total++; if (vga_x !== 10'd0) $display("FAIL reset_x got %0d exp 0", vga_x); else passed++;
    total++; if (vga_y !== 9'd0) $display("FAIL reset_y got %0d exp 0", vga_y); else passed++;
    total++; if (vga_color !== 9'd0) $display("FAIL reset_color got %0d exp 0", vga_color); else passed++;
    total++; if ({d1_ready, d0_ready} !== 2'b00) $display("FAIL reset_ready got %0b exp 00", {d1_ready, d0_ready}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passed++;
    tick();
    Resetn = 1;
  endtask

  task automatic test_round_robin;
    logic exp0;
    Resetn = 0; #2; Resetn = 1;
    d0_x = 10'd10; d0_y = 9'd20; d0_color = 9'h007;
    d1_x = 10'd30; d1_y = 9'd40; d1_color = 9'h038;
    d0_valid = 1; d1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      #4;
      total++; if ({d1_ready, d0_ready} !== {~exp0, exp0}) $display("FAIL rr_gnt%0d got %0b exp %0b", i, {d1_ready, d0_ready}, {~exp0, exp0}); else passed++;
      tick();
      total++; if (vga_plot !== 1'b1 || vga_x !== (exp0 ? 10'd10 : 10'd30)) $display("FAIL rr_out%0d got plot %0b x %0d exp plot 1 x %0d", i, vga_plot, vga_x, exp0 ? 10 : 30); else passed++;
    end
    d0_valid = 0; d1_valid = 0;
    tick();
    total++; if (vga_plot !== 1'b0 || vga_x !== 10'd30 || vga_y !== 9'd40 || vga_color !== 9'h038) $display("FAIL rr_hold got plot %0b x %0d y %0d c %0h exp plot 0 x 30 y 40 c 38", vga_plot, vga_x, vga_y, vga_color); else passed++;
  endtask

  task automatic test_single_drawer;
    // one d0 grant moves the pointer to d1 first
    d0_valid = 1;
    #4;
    total++; if (d0_ready !== 1'b1) $display("FAIL single_pre got %0b exp 1", d0_ready); else passed++;
    tick();
    d0_valid = 0;
    d1_valid = 1; d1_x = 10'd300; d1_y = 9'd400; d1_color = 9'h1AB;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++; if ({d1_ready, d0_ready} !== 2'b10) $display("FAIL single_rdy%0d got %0b exp 10", i, {d1_ready, d0_ready}); else passed++;
      tick();
      total++; if (vga_plot !== 1'b1 || vga_x !== 10'd300 || vga_y !== 9'd400 || vga_color !== 9'h1AB) $display("FAIL single_out%0d got plot %0b x %0d y %0d exp plot 1 x 300 y 400", i, vga_plot, vga_x, vga_y); else passed++;
    end
    // pointer must now favour d0
    d0_valid = 1;
    #4;
    total++; if ({d1_ready, d0_ready} !== 2'b01) $display("FAIL single_ptr got %0b exp 01", {d1_ready, d0_ready}); else passed++;
    tick();
    d0_valid = 0; d1_valid = 0;
  endtask

  task automatic test_eraser_priority;
    d0_valid = 1; d0_x = 10'd50; d0_y = 9'd60; d0_color = 9'h1C0;
    erase_active = 1; erase_write = 0;
    #4;
    total++; if (d0_ready !== 1'b0) $display("FAIL ers_rise_rdy got %0b exp 0", d0_ready); else passed++;
    tick();
    total++; if (vga_plot !== 1'b0 || busy !== 1'b1) $display("FAIL ers_rise_out got plot %0b busy %0b exp plot 0 busy 1", vga_plot, busy); else passed++;
    for (int i = 0; i < 3; i++) begin
      erase_write = 1; erase_x = 10'(130 + i); erase_y = 9'd5; erase_color = 9'h000;
      #4;
      total++; if (d0_ready !== 1'b0) $display("FAIL ers_rdy%0d got %0b exp 0", i, d0_ready); else passed++;
      tick();
      total++; if (vga_plot !== 1'b1 || vga_x !== 10'(130 + i) || vga_y !== 9'd5 || vga_color !== 9'd0) $display("FAIL ers_out%0d got plot %0b x %0d y %0d c %0d exp plot 1 x %0d y 5 c 0", i, vga_plot, vga_x, vga_y, vga_color, 130 + i); else passed++;
    end
    // pass ends: locked out for cycles N..N+2, granted at N+3
    erase_active = 0; erase_write = 0;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++; if (d0_ready !== 1'b0) $display("FAIL holdoff_rdy%0d got %0b exp 0", i, d0_ready); else passed++;
      tick();
    end
    #4;
    total++; if (d0_ready !== 1'b1) $display("FAIL holdoff_grant got %0b exp 1", d0_ready); else passed++;
    tick();
    total++; if (vga_plot !== 1'b1 || vga_x !== 10'd50 || busy !== 1'b0) $display("FAIL holdoff_out got plot %0b x %0d busy %0b exp plot 1 x 50 busy 0", vga_plot, vga_x, busy); else passed++;
    d0_valid = 0;
  endtask

  task automatic test_holdoff_reentry;
    d0_valid = 1; d0_x = 10'd77;
    erase_active = 1; tick();   // DRAW -> ERASE
    erase_active = 0; tick();   // ERASE -> HOLDOFF
    tick();                     // second holdoff cycle next
    erase_active = 1;
    #4;
    total++; if (d0_ready !== 1'b0) $display("FAIL reentry_rdy got %0b exp 0", d0_ready); else passed++;
    tick();
    erase_active = 0;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++; if (d0_ready !== 1'b0) $display("FAIL reentry_lock%0d got %0b exp 0", i, d0_ready); else passed++;
      tick();
    end
    #4;
    total++; if (d0_ready !== 1'b1) $display("FAIL reentry_grant got %0b exp 1", d0_ready); else passed++;
    tick();
    total++; if (vga_plot !== 1'b1 || vga_x !== 10'd77) $display("FAIL reentry_out got plot %0b x %0d exp plot 1 x 77", vga_plot, vga_x); else passed++;
    d0_valid = 0;
  endtask

  task automatic test_reset_mid;
    erase_active = 1; erase_write = 1;
    erase_x = 10'd200; erase_y = 9'd100; erase_color = 9'h155;
    tick();
    total++; if (vga_plot !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_pre got plot %0b busy %0b exp 1 1", vga_plot, busy); else passed++;
    erase_active = 0; erase_write = 0;
    d0_valid = 1; d0_x = 10'd11; d0_y = 9'd22; d0_color = 9'h0F0;
    #1; Resetn = 0;
    #1;
    total++; if (vga_plot !== 1'b0 || vga_x !== 10'd0 || vga_y !== 9'd0) $display("FAIL midrst_out got plot %0b x %0d y %0d exp 0 0 0", vga_plot, vga_x, vga_y); else passed++;
    total++; if (d0_ready !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_ctl got rdy %0b busy %0b exp 0 0", d0_ready, busy); else passed++;
    #1; Resetn = 1;
    #1;
    total++; if (d0_ready !== 1'b1) $display("FAIL midrst_restart got %0b exp 1", d0_ready); else passed++;
    tick();
    total++; if (vga_plot !== 1'b1 || vga_x !== 10'd11 || vga_color !== 9'h0F0) $display("FAIL midrst_plot got plot %0b x %0d exp plot 1 x 11", vga_plot, vga_x); else passed++;
    d0_valid = 0;
  endtask

`ifdef VGA_CLIP_EN
  task automatic test_clip;
    Resetn = 0; #2; Resetn = 1;
    total++; if (clip_count !== 16'd0) $display("FAIL clip_reset got %0d exp 0", clip_count); else passed++;
    d0_valid = 1; d0_x = 10'd700; d0_y = 9'd10;
    #4;
    total++; if (d0_ready !== 1'b1) $display("FAIL clip_x_rdy got %0b exp 1", d0_ready); else passed++;
    tick();
    total++; if (vga_plot !== 1'b0 || clip_count !== 16'd1) $display("FAIL clip_x got plot %0b cnt %0d exp plot 0 cnt 1", vga_plot, clip_count); else passed++;
    d0_valid = 0;
    d1_valid = 1; d1_x = 10'd5; d1_y = 9'd480;
    tick();
    total++; if (vga_plot !== 1'b0 || clip_count !== 16'd2) $display("FAIL clip_y got plot %0b cnt %0d exp plot 0 cnt 2", vga_plot, clip_count); else passed++;
    d1_x = 10'd639; d1_y = 9'd479;
    tick();
    total++; if (vga_plot !== 1'b1 || vga_x !== 10'd639 || clip_count !== 16'd2) $display("FAIL clip_edge got plot %0b x %0d cnt %0d exp plot 1 x 639 cnt 2", vga_plot, vga_x, clip_count); else passed++;
    d1_valid = 0;
  endtask
`else
  task automatic test_clip;
    d0_valid = 1; d0_x = 10'd700; d0_y = 9'd10;
    #4;
    total++; if (d0_ready !== 1'b1) $display("FAIL noclip_rdy got %0b exp 1", d0_ready); else passed++;
    tick();
    total++; if (vga_plot !== 1'b1 || vga_x !== 10'd700) $display("FAIL noclip_out got plot %0b x %0d exp plot 1 x 700", vga_plot, vga_x); else passed++;
    d0_valid = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_drawer();
    test_eraser_priority();
    test_holdoff_reentry();
    test_reset_mid();
    test_clip();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
